// File: rtl/alu_seq.sv
// alu_seq: sequential, handshaked ALU with owned C/Z/N flag register.
// One operation per transaction (valid/ready in, valid/ready out).
// Shifts run one bit per cycle unless ALU_FAST_SHIFT_EN is defined, in which
// case a single-cycle barrel shifter completes them with 1-cycle latency.
// WORD_SIZE defaults to the `WORD_SIZE macro (8 when the macro is not set).

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

package alu_seq_pkg;
  // Codes 11..15 are undefined: they produce out=0 and leave the flags alone.
  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_ADC = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_CMP = 4'd6,
    OP_INC = 4'd7,
    OP_DEC = 4'd8,
    OP_SHR = 4'd9,
    OP_SHL = 4'd10
  } opcode_t;
endpackage

module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WORD_SIZE = `WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  opcode_t              opcode,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out,
  output logic                 flag_c,
  output logic                 flag_z,
  output logic                 flag_n
);

  // Shift counter must hold WORD_SIZE itself (b >= WORD_SIZE saturates).
  localparam int CNT_W = $clog2(WORD_SIZE + 1);
  localparam logic [WORD_SIZE:0] LP_W_WIDE = (WORD_SIZE + 1)'(WORD_SIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [WORD_SIZE-1:0]   r_out;
  logic                   r_flag_c;
  logic                   r_flag_z;
  logic                   r_flag_n;
  logic                   r_out_valid;

  logic [WORD_SIZE:0]     w_add;
  logic [WORD_SIZE:0]     w_adc;
  logic [WORD_SIZE:0]     w_sub;
  logic                   w_b_zero;
  logic [CNT_W-1:0]       w_shamt;
  logic [WORD_SIZE-1:0]   w_res;
  logic                   w_c;
  logic                   w_wr_c;
  logic                   w_wr_zn;
  logic                   w_accept;

`ifdef ALU_FAST_SHIFT_EN
  logic [2*WORD_SIZE-1:0] w_shl_wide;
  logic [2*WORD_SIZE-1:0] w_shr_wide;
  logic [WORD_SIZE-1:0]   w_fast_res;
  logic                   w_fast_c;
`else
  logic [WORD_SIZE-1:0]   r_work;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_shl;
  logic                   w_go_exec;
  logic [WORD_SIZE-1:0]   w_step_word;
  logic                   w_step_c;
  logic                   w_step_last;
`endif

  // in_ready is a pure function of state, but must read 0 while reset is held.
  assign in_ready  = rst_n & (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign flag_c    = r_flag_c;
  assign flag_z    = r_flag_z;
  assign flag_n    = r_flag_n;

  assign w_accept  = in_valid & in_ready;

  // Carry-producing arithmetic is done one bit wider so C falls out as the MSB.
  assign w_add    = {1'b0, a} + {1'b0, b};
  assign w_adc    = w_add + {{WORD_SIZE{1'b0}}, r_flag_c};
  assign w_sub    = {1'b0, a} - {1'b0, b};
  assign w_b_zero = (b == '0);
  assign w_shamt  = ({1'b0, b} >= LP_W_WIDE) ? CNT_W'(WORD_SIZE) : b[CNT_W-1:0];

`ifdef ALU_FAST_SHIFT_EN
  // Barrel shift in a double-width word: the last bit shifted out lands just
  // beyond the kept half (bit W for SHL, bit W-1 for SHR).
  assign w_shl_wide = {{WORD_SIZE{1'b0}}, a} << w_shamt;
  assign w_shr_wide = {a, {WORD_SIZE{1'b0}}} >> w_shamt;
  assign w_fast_res = (opcode == OP_SHL) ? w_shl_wide[WORD_SIZE-1:0]
                                         : w_shr_wide[2*WORD_SIZE-1:WORD_SIZE];
  assign w_fast_c   = (opcode == OP_SHL) ? w_shl_wide[WORD_SIZE]
                                         : w_shr_wide[WORD_SIZE-1];
`else
  // One iterative shift step on the working register; C is the bit leaving it.
  assign w_step_word = r_shl ? (r_work << 1) : (r_work >> 1);
  assign w_step_c    = r_shl ? r_work[WORD_SIZE-1] : r_work[0];
  assign w_step_last = (r_cnt == CNT_W'(1));
`endif

  // Result and flag-write enables for an operation that completes on accept.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    w_res   = '0;
    w_c     = r_flag_c;
    w_wr_c  = 1'b0;
    w_wr_zn = 1'b1;
`ifndef ALU_FAST_SHIFT_EN
    w_go_exec = 1'b0;
`endif
    case (opcode)
      OP_ADD: begin
        {w_c, w_res} = w_add;
        w_wr_c       = 1'b1;
      end
      OP_ADC: begin
        {w_c, w_res} = w_adc;
        w_wr_c       = 1'b1;
      end
      OP_SUB: begin
        {w_c, w_res} = w_sub;
        w_wr_c       = 1'b1;
      end
      OP_AND: w_res = a & b;
      OP_OR:  w_res = a | b;
      OP_XOR: w_res = a ^ b;
      OP_CMP: w_res = (a == b) ? WORD_SIZE'(1) : '0;
      OP_INC: w_res = a + WORD_SIZE'(1);
      OP_DEC: w_res = a - WORD_SIZE'(1);
      OP_SHL, OP_SHR: begin
        // b == 0 passes a through and leaves C untouched in both modes.
        w_res = a;
        if (!w_b_zero) begin
`ifdef ALU_FAST_SHIFT_EN
          w_res  = w_fast_res;
          w_c    = w_fast_c;
          w_wr_c = 1'b1;
`else
          w_go_exec = 1'b1;
`endif
        end
      end
      default: w_wr_zn = 1'b0;
    endcase
  end

  // Handshake FSM plus the result/flag registers it owns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out       <= '0;
      r_flag_c    <= 1'b0;
      r_flag_z    <= 1'b0;
      r_flag_n    <= 1'b0;
      r_out_valid <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      r_work      <= '0;
      r_cnt       <= '0;
      r_shl       <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values of the others, independent of statement order.
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if (w_go_exec) begin
              r_work  <= a;
              r_cnt   <= w_shamt;
              r_shl   <= (opcode == OP_SHL);
              r_state <= S_EXEC;
            end else
`endif
            begin
              r_out <= w_res;
              if (w_wr_c) r_flag_c <= w_c;
              if (w_wr_zn) begin
                r_flag_z <= ~|w_res;
                r_flag_n <= w_res[WORD_SIZE-1];
              end
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
`ifndef ALU_FAST_SHIFT_EN
        S_EXEC: begin
          r_work <= w_step_word;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (w_step_last) begin
            r_out       <= w_step_word;
            r_flag_c    <= w_step_c;
            r_flag_z    <= ~|w_step_word;
            r_flag_n    <= w_step_word[WORD_SIZE-1];
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed test-plan scenarios followed by random transactions,
// each checked against an arithmetic reference model of the ALU rules.
// Honours ALU_FAST_SHIFT_EN for expected shift latency.

module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  opcode_t      opcode;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_o;
  logic         flag_c;
  logic         flag_z;
  logic         flag_n;

  int checks   = 0;
  int failures = 0;

  // Reference flag state and record of the last completed transaction.
  bit         m_c = 1'b0;
  bit         m_z = 1'b0;
  bit         m_n = 1'b0;
  int         last_lat;
  logic [7:0] last_out;

  alu_seq #(.WORD_SIZE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .a         (a_i),
    .b         (b_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_o),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .flag_n    (flag_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural model: computes result and latency, and updates m_c/m_z/m_n.
  task automatic model(input opcode_t op, input int av, input int bv,
                       output int res, output int lat);
    int  k;
    bit  def;
    def = 1'b1;
    lat = 1;
    res = 0;
    k   = (bv > W) ? W : bv;
    case (op)
      OP_ADD: begin res = av + bv;              m_c = (res > 255); res = res & 255; end
      OP_ADC: begin res = av + bv + int'(m_c);  m_c = (res > 255); res = res & 255; end
      OP_SUB: begin m_c = (av < bv); res = (av - bv) & 255; end
      OP_AND: res = av & bv;
      OP_OR:  res = av | bv;
      OP_XOR: res = av ^ bv;
      OP_CMP: res = (av == bv) ? 1 : 0;
      OP_INC: res = (av + 1) & 255;
      OP_DEC: res = (av - 1) & 255;
      OP_SHL: begin
        if (k == 0) res = av;
        else begin
          res = (av << k) & 255;
          m_c = bit'((av >> (W - k)) & 1);
`ifndef ALU_FAST_SHIFT_EN
          lat = 1 + k;
`endif
        end
      end
      OP_SHR: begin
        if (k == 0) res = av;
        else begin
          res = av >> k;
          m_c = bit'((av >> (k - 1)) & 1);
`ifndef ALU_FAST_SHIFT_EN
          lat = 1 + k;
`endif
        end
      end
      default: def = 1'b0;
    endcase
    if (def) begin
      m_z = (res == 0);
      m_n = bit'((res >> 7) & 1);
    end
  endtask

  // Full transaction starting at a negedge with the DUT idle; ends at the
  // negedge after the output transfer, ready for a back-to-back accept.
  task automatic run_op(input opcode_t op, input logic [7:0] av,
                        input logic [7:0] bv, input int hold);
    int         exp_res;
    int         exp_lat;
    int         lat;
    logic [7:0] s_out;
    logic       s_c;
    logic       s_z;
    logic       s_n;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    opcode   = op;
    a_i      = av;
    b_i      = bv;
    in_valid = 1'b1;
    model(op, int'(av), int'(bv), exp_res, exp_lat);
    @(negedge clk);
    // Scramble inputs after accept; the DUT must ignore them.
    in_valid = 1'b0;
    opcode   = opcode_t'(4'($urandom_range(0, 15)));
    a_i      = 8'($urandom);
    b_i      = 8'($urandom);
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      check("in_ready_busy", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    check("out", 32'(out_o), exp_res);
    check("flag_c", 32'(flag_c), 32'(m_c));
    check("flag_z", 32'(flag_z), 32'(m_z));
    check("flag_n", 32'(flag_n), 32'(m_n));
    check("in_ready_done", 32'(in_ready), 32'd0);
    s_out = out_o;
    s_c   = flag_c;
    s_z   = flag_z;
    s_n   = flag_n;
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_ready", 32'(in_ready), 32'd0);
      check("hold_out", 32'(out_o), 32'(s_out));
      check("hold_flags", 32'({flag_c, flag_z, flag_n}), 32'({s_c, s_z, s_n}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
    last_lat = lat;
    last_out = s_out;
  endtask

`ifdef ALU_FAST_SHIFT_EN
  localparam int LAT_SHL3 = 1;
  localparam int LAT_SHR9 = 1;
`else
  localparam int LAT_SHL3 = 4;
  localparam int LAT_SHR9 = 9;
`endif

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    opcode    = OP_ADD;
    a_i       = '0;
    b_i       = '0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(out_o), 32'd0);
    check("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // ADD with carry out, then back-to-back ADC consuming it.
    run_op(OP_ADD, 8'hF0, 8'h20, 0);
    check("add_out", 32'(last_out), 32'h10);
    check("add_flags", 32'({flag_c, flag_z, flag_n}), 32'b100);
    check("add_lat", last_lat, 1);
    run_op(OP_ADC, 8'h01, 8'h01, 0);
    check("adc_out", 32'(last_out), 32'h03);
    check("adc_c", 32'(flag_c), 32'd0);
    run_op(OP_SUB, 8'h00, 8'h01, 0);
    check("sub_borrow", 32'({last_out, flag_c, flag_n}), 32'({8'hFF, 2'b11}));
    run_op(OP_SUB, 8'h05, 8'h05, 0);
    check("sub_zero", 32'({last_out, flag_z, flag_c}), 32'({8'h00, 2'b10}));

    // Iterative shifts, including saturated amount.
    run_op(OP_SHL, 8'h81, 8'd3, 0);
    check("shl_out", 32'({last_out, flag_c}), 32'({8'h08, 1'b0}));
    check("shl_lat", last_lat, LAT_SHL3);
    run_op(OP_SHR, 8'h80, 8'd9, 0);
    check("shr_out", 32'({last_out, flag_c, flag_z}), 32'({8'h00, 2'b11}));
    check("shr_lat", last_lat, LAT_SHR9);

    // Back-pressure for five cycles.
    run_op(OP_AND, 8'hF0, 8'h3C, 5);
    check("and_out", 32'(last_out), 32'h30);

    // Reset in the middle of a long shift.
    opcode   = OP_SHL;
    a_i      = 8'hFF;
    b_i      = 8'd7;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", 32'(out_valid), 32'd0);
    rst_n = 1'b0;
    m_c = 1'b0;
    m_z = 1'b0;
    m_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out_o), 32'd0);
    check("mid_rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    run_op(OP_INC, 8'hFF, 8'h00, 0);
    check("inc_wrap", 32'({last_out, flag_z, flag_c}), 32'({8'h00, 2'b10}));

    // Undefined opcode leaves C=1/Z=0/N=1 untouched.
    run_op(OP_SUB, 8'h00, 8'h01, 0);
    run_op(opcode_t'(4'd13), 8'h12, 8'h34, 0);
    check("undef_out", 32'(last_out), 32'h00);
    check("undef_flags", 32'({flag_c, flag_z, flag_n}), 32'b101);
    check("undef_lat", last_lat, 1);

    // Random transactions, shift amounts biased toward the interesting range.
    for (int i = 0; i < 40; i++) begin
      opcode_t    r_op;
      logic [7:0] r_a;
      logic [7:0] r_b;
      r_op = opcode_t'(4'($urandom_range(0, 15)));
      r_a  = 8'($urandom);
      r_b  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 10)) : 8'($urandom);
      run_op(r_op, r_a, r_b, int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
